// File: rtl/key_vaild_gen.sv
// Debounces one raw push-button into press/release/long-press pulses and a chaser enable level.
// Latency: a stable key_in level yields key_press/key_release in the cycle after edge DEBOUNCE_CYC+4.
// No backpressure: pulses are single-cycle and unconditional; the consumer must sample every cycle.
module key_vaild_gen #(
   parameter logic [23:0] DEBOUNCE_CYC = 24'd999_999,
   parameter logic [25:0] LONG_CYC     = 26'd49_999_999,
   parameter logic        KEY_ACTIVE   = 1'b0
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic key_in,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic vaild
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   // two-flop synchroniser; key_s is the only view of the pin the FSM ever uses
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;

   state_t      state_q, state_d;
   logic [23:0] db_cnt_q, db_cnt_d;
   logic [25:0] hold_cnt_q, hold_cnt_d;
   logic        long_flag_q, long_flag_d;

   logic        key_state_q, key_state_d;
   logic        key_press_q, key_press_d;
   logic        key_release_q, key_release_d;
   logic        key_long_q, key_long_d;
   logic        vaild_q, vaild_d;

   logic        key_s;
   logic        act;

   assign key_s = sync2_q;
   assign act   = (key_s == KEY_ACTIVE);

   // next-state logic: synchroniser shift, press/release FSM, counters and registered outputs
   always_comb begin
      sync1_d       = key_in;
      sync2_d       = sync1_q;

      state_d       = state_q;
      db_cnt_d      = db_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      long_flag_d   = long_flag_q;

      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      key_long_d    = 1'b0;
      vaild_d       = vaild_q;

      case (state_q)
         IDLE: begin
            db_cnt_d    = 24'd0;
            hold_cnt_d  = 26'd0;
            long_flag_d = 1'b0;
            if (act) begin
               state_d = PRESS_DB;
            end
         end

         PRESS_DB: begin
            if (!act) begin
               // bounce: level fell back before the debounce window closed
               state_d  = IDLE;
               db_cnt_d = 24'd0;
            end else if (db_cnt_q == DEBOUNCE_CYC) begin
               state_d     = HELD;
               db_cnt_d    = 24'd0;
               key_press_d = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 24'd1;
            end
         end

         HELD: begin
            // hold_cnt saturates so it can never wrap back past LONG_CYC
            if (hold_cnt_q != LONG_CYC) begin
               hold_cnt_d = hold_cnt_q + 26'd1;
            end
            // long_flag limits the long event to once per press
            if ((hold_cnt_q == LONG_CYC) && !long_flag_q) begin
               key_long_d  = 1'b1;
               long_flag_d = 1'b1;
               vaild_d     = 1'b0;
            end
            if (!act) begin
               state_d  = RELEASE_DB;
               db_cnt_d = 24'd0;
            end
         end

         RELEASE_DB: begin
            if (act) begin
               // bounce on release: resume the hold without losing hold_cnt/long_flag
               state_d  = HELD;
               db_cnt_d = 24'd0;
            end else if (db_cnt_q == DEBOUNCE_CYC) begin
               state_d       = IDLE;
               db_cnt_d      = 24'd0;
               key_release_d = 1'b1;
               // only a short press toggles the enable; a long press already forced it low
               if (!long_flag_q) begin
                  vaild_d = ~vaild_q;
               end
            end else begin
               db_cnt_d = db_cnt_q + 24'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      key_state_d = (state_d == HELD) || (state_d == RELEASE_DB);
   end

   // single state register for synchroniser, FSM, counters and outputs; reset wins over everything
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync1_q       <= ~KEY_ACTIVE;
         sync2_q       <= ~KEY_ACTIVE;
         state_q       <= IDLE;
         db_cnt_q      <= 24'd0;
         hold_cnt_q    <= 26'd0;
         long_flag_q   <= 1'b0;
         key_state_q   <= 1'b0;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
         key_long_q    <= 1'b0;
         vaild_q       <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         state_q       <= state_d;
         db_cnt_q      <= db_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         long_flag_q   <= long_flag_d;
         key_state_q   <= key_state_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
         key_long_q    <= key_long_d;
         vaild_q       <= vaild_d;
      end
   end

   assign key_state   = key_state_q;
   assign key_press   = key_press_q;
   assign key_release = key_release_q;
   assign key_long    = key_long_q;
   assign vaild       = vaild_q;

endmodule

// File: tb/tb_key_vaild_gen.sv
// Bench for key_vaild_gen with short debounce/long windows.
// Stimulus pushes expected pulses (kind, cycle, vaild, key_state) into a scoreboard queue.
// A negedge monitor pops and compares on every pulse, flags missing, extra and overlapping pulses.
module tb_key_vaild_gen;

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int   kind;
      int   cyc;
      logic vaild;
      logic state;
   } ev_t;

   logic sys_clk;
   logic rst;
   logic key_in;
   logic key_state;
   logic key_press;
   logic key_release;
   logic key_long;
   logic vaild;

   int   cyc;
   int   n_chk;
   int   n_fail;
   ev_t  sb[$];
   logic prev_vaild;

   key_vaild_gen #(
      .DEBOUNCE_CYC (24'd9),
      .LONG_CYC     (26'd49),
      .KEY_ACTIVE   (1'b0)
   ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .vaild       (vaild)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // posedge counter: at a negedge, cyc equals the number of rising edges so far
   initial cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      if (k == K_PRESS) return "press";
      if (k == K_REL)   return "release";
      return "long";
   endfunction

   task automatic push(input int kind, input int at, input logic v, input logic st);
      ev_t e;
      e.kind  = kind;
      e.cyc   = at;
      e.vaild = v;
      e.state = st;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // assumes we sit at a negedge: set the pin, then let n cycles pass
   task automatic drive(input logic level, input int n);
      key_in = level;
      repeat (n) @(negedge sys_clk);
   endtask

   // same as drive, but key_state must stay high on every cycle of the segment
   task automatic drive_held(input logic level, input int n);
      key_in = level;
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         chk("key_state_during_glitch", key_state, 1'b1);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_key_state",   key_state,   1'b0);
      chk("rst_key_press",   key_press,   1'b0);
      chk("rst_key_release", key_release, 1'b0);
      chk("rst_key_long",    key_long,    1'b0);
      chk("rst_vaild",       vaild,       1'b0);
   endtask

   task automatic check_pulse(input int k);
      ev_t e;
      n_chk++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: pulse at cycle %0d, none expected", kname(k), cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.cyc != cyc || e.vaild !== vaild || e.state !== key_state) begin
            n_fail++;
            $display("FAIL pulse_%s: got kind=%s cyc=%0d vaild=%b key_state=%b, expected kind=%s cyc=%0d vaild=%b key_state=%b",
                     kname(k), kname(k), cyc, vaild, key_state,
                     kname(e.kind), e.cyc, e.vaild, e.state);
         end
      end
   endtask

   // monitor: decoupled from stimulus, reacts to whatever the DUT presents
   initial begin
      ev_t dropped;
      int  npulse;
      prev_vaild = 1'b0;
      forever begin
         @(negedge sys_clk);
         while (sb.size() > 0 && cyc > sb[0].cyc) begin
            dropped = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_%s: no pulse seen, expected at cycle %0d (now %0d)",
                     kname(dropped.kind), dropped.cyc, cyc);
         end
         npulse = int'(key_press === 1'b1) + int'(key_release === 1'b1) + int'(key_long === 1'b1);
         if (npulse > 0) begin
            n_chk++;
            if (npulse > 1) begin
               n_fail++;
               $display("FAIL exclusive_pulses: %0d pulses high at cycle %0d, expected 1", npulse, cyc);
            end
         end
         if (key_press === 1'b1)   check_pulse(K_PRESS);
         if (key_release === 1'b1) check_pulse(K_REL);
         if (key_long === 1'b1)    check_pulse(K_LONG);
         if (rst === 1'b0) begin
            n_chk++;
            if (vaild !== prev_vaild && key_release !== 1'b1 && key_long !== 1'b1) begin
               n_fail++;
               $display("FAIL vaild_stable: vaild went %b->%b at cycle %0d without a release/long pulse",
                        prev_vaild, vaild, cyc);
            end
         end
         prev_vaild = vaild;
      end
   end

   initial begin
      int c;
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      key_in = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk_reset_outputs();
      rst = 1'b0;
      drive(1'b1, 5);

      // clean short press: vaild 0->1 on release
      c = cyc; push(K_PRESS, c + 13, 1'b0, 1'b1); drive(1'b0, 40);
      c = cyc; push(K_REL,   c + 13, 1'b1, 1'b0); drive(1'b1, 40);

      // press bounce: 0 x5, 1 x3, then steady 0
      drive(1'b0, 5);
      drive(1'b1, 3);
      c = cyc; push(K_PRESS, c + 13, 1'b1, 1'b1); drive(1'b0, 30);

      // release bounce: 1 x4, 0 x2, then steady 1; key_state must hold through the glitch
      drive_held(1'b1, 4);
      drive_held(1'b0, 2);
      c = cyc; push(K_REL, c + 13, 1'b0, 1'b0); drive(1'b1, 40);

      // set vaild=1 with a short press, then a 100-cycle long press
      c = cyc; push(K_PRESS, c + 13, 1'b0, 1'b1); drive(1'b0, 20);
      c = cyc; push(K_REL,   c + 13, 1'b1, 1'b0); drive(1'b1, 20);
      c = cyc;
      push(K_PRESS, c + 13, 1'b1, 1'b1);
      push(K_LONG,  c + 63, 1'b0, 1'b1);
      drive(1'b0, 100);
      c = cyc; push(K_REL, c + 13, 1'b0, 1'b0); drive(1'b1, 40);

      // three short presses toggle vaild 0->1->0->1
      for (int i = 0; i < 3; i++) begin
         c = cyc; push(K_PRESS, c + 13, logic'(i % 2 == 1), 1'b1); drive(1'b0, 20);
         c = cyc; push(K_REL,   c + 13, logic'(i % 2 == 0), 1'b0); drive(1'b1, 20);
      end

      // reset while HELD with vaild=1 and the key still down
      c = cyc; push(K_PRESS, c + 13, 1'b1, 1'b1); drive(1'b0, 20);
      rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk_reset_outputs();
      rst = 1'b0;
      c = cyc; push(K_PRESS, c + 13, 1'b0, 1'b1); drive(1'b0, 30);
      c = cyc; push(K_REL,   c + 13, 1'b1, 1'b0); drive(1'b1, 30);

      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expected pulses still pending, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/key_vaild_gen.md
Name: key_vaild_gen

Overview:
- Input-side companion to the 4-bit LED chaser: turns one raw, bouncing push-button into the clean `vaild` level that enables the chaser.
- Synchronises and debounces the key, runs a press/release FSM, and emits single-cycle press, release and long-press pulses.
- Sits between the board key pin and the chaser's `vaild` input, in the `sys_clk` domain.

Parameters:
- DEBOUNCE_CYC, 24'd999_999: cycles the synchronised level must hold before it is accepted (20 ms at 50 MHz).
- LONG_CYC, 26'd49_999_999: cycles the key must stay debounced-pressed before the long-press event (1 s at 50 MHz).
- KEY_ACTIVE, 1'b0: level of `key_in` that means pressed.

Ports:
- sys_clk  input  1  50 MHz system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw asynchronous key pin.
- key_state  output  1  debounced key level, 1 = pressed.
- key_press  output  1  one-cycle pulse on an accepted press.
- key_release  output  1  one-cycle pulse on an accepted release.
- key_long  output  1  one-cycle pulse when a press reaches LONG_CYC.
- vaild  output  1  chaser enable level.

Behaviour:
- Clock and reset: one clock (`sys_clk`); reset (`rst`) is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - FSM returns to IDLE; db_cnt, hold_cnt and long_flag clear to 0.
  - Both synchroniser flops load ~KEY_ACTIVE.
  - All outputs read 0 after that edge.
  - Reset overrides every other event.
- Synchroniser: two flops on `key_in`, giving key_s. "act" means key_s == KEY_ACTIVE. No other logic uses `key_in` directly.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. All outputs are registered.
  - IDLE: db_cnt=0, hold_cnt=0, long_flag=0. If act, go to PRESS_DB.
  - PRESS_DB:
    - If !act: go to IDLE, db_cnt=0 (bounce rejected, no pulse).
    - Else if db_cnt == DEBOUNCE_CYC: go to HELD, db_cnt=0, key_press=1 for one cycle.
    - Else db_cnt+1.
  - HELD:
    - hold_cnt increments and saturates at LONG_CYC.
    - When hold_cnt == LONG_CYC and long_flag == 0: key_long=1 for one cycle and long_flag=1. This fires at most once per press.
    - If !act: go to RELEASE_DB, db_cnt=0. hold_cnt is not cleared.
  - RELEASE_DB:
    - If act: go back to HELD, db_cnt=0 (bounce rejected). hold_cnt and long_flag are kept.
    - Else if db_cnt == DEBOUNCE_CYC: go to IDLE, key_release=1 for one cycle.
    - Else db_cnt+1. hold_cnt holds its value.
- key_state: 1 exactly while the FSM is in HELD or RELEASE_DB.
- vaild:
  - Toggles in the same cycle key_release pulses, only if long_flag == 0 (short press).
  - Cleared to 0 in the same cycle key_long pulses.
  - A long press therefore always leaves vaild=0, and its release does not toggle it.
- Latency: the key_in level must be stable from before edge 1 (the first edge that samples it). key_press (or key_release) is then high in the cycle after rising edge DEBOUNCE_CYC+4.
- Exclusivity:
  - key_press, key_release and key_long are never high in the same cycle.
  - Each accepted press produces exactly one key_press and one key_release.
- Width rules:
  - db_cnt is 24 bits and hold_cnt is 26 bits, both wide enough for the defaults.
  - Counters never wrap: db_cnt clears on every state change, and hold_cnt saturates.
- Reset during a held key: after rst falls, IDLE sees act and the key goes through a full PRESS_DB. The held key is treated as a new press: one key_press, and vaild stays 0 until its short release.

Test Plan:
(All scenarios use DEBOUNCE_CYC=9 and LONG_CYC=49 for simulation.)
1. Clean press: key_in held 0 for 40 cycles, then 1 for 40 cycles -> key_press pulses after edge 13 of the press and key_release after edge 13 of the release; vaild changes 0->1 at the release pulse; key_long stays 0.
2. Press bounce: key_in 0 for 5 cycles, 1 for 3, then 0 steady -> no pulse during the glitch; exactly one key_press, 13 edges after the final 0 is first sampled.
3. Release bounce: while pressed, key_in goes 1 for 4 cycles, 0 for 2, then 1 steady -> key_state stays 1 throughout the glitch; exactly one key_release.
4. Long press: vaild=1, then key_in held 0 for 100 cycles and released -> one key_long pulse, 50 cycles after key_press; vaild drops to 0 in that cycle; the following key_release leaves vaild at 0; only one key_long despite the extra hold.
5. Toggle sequence: three short presses of 20 cycles each, separated by 20 released cycles -> vaild goes 0->1->0->1; three key_press and three key_release pulses.
6. Reset mid-press: rst=1 for 2 cycles while in HELD with vaild=1 and key_in still 0 -> all outputs read 0 after the reset edge; after rst falls, a new key_press arrives after the full debounce; vaild stays 0 until the subsequent release, where it toggles to 1.
